// File: rtl/button_sync_debounce_if.sv
// -----------------------------------------------------------------------------
// button_sync_debounce_if
// Consumer-facing bundle of the push-button front-end.
//   i_press_ack      consumer accepts the pending press
//   o_button_level   debounced level, 1 = pressed
//   o_press_pulse    1-cycle strobe on an accepted press (and on each repeat)
//   o_release_pulse  1-cycle strobe on an accepted release
//   o_press_req      pending-press request, held until acknowledged
//   o_overrun        sticky: a press arrived while o_press_req was already high
// Modports: master = debouncer side, slave = consumer side (e.g. UART TX start).
// -----------------------------------------------------------------------------
interface button_sync_debounce_if;
    logic i_press_ack;
    logic o_button_level;
    logic o_press_pulse;
    logic o_release_pulse;
    logic o_press_req;
    logic o_overrun;

    modport master (
        input  i_press_ack,
        output o_button_level,
        output o_press_pulse,
        output o_release_pulse,
        output o_press_req,
        output o_overrun
    );

    modport slave (
        output i_press_ack,
        input  o_button_level,
        input  o_press_pulse,
        input  o_release_pulse,
        input  o_press_req,
        input  o_overrun
    );
endinterface

// File: rtl/button_sync_debounce.sv
// -----------------------------------------------------------------------------
// button_sync_debounce
// Push-button front-end: synchronises the raw pin, debounces it with a
// four-state FSM plus qualify counter, and produces a clean level, press /
// release strobes and a press request held until the consumer acknowledges.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous, active-low reset
//   i_button_raw  raw asynchronous button pin
//   btn           button_sync_debounce_if.master (ack in; level, strobes,
//                 request and overrun flag out)
//
// Optional feature: define BTN_AUTO_REPEAT_EN to add auto-repeat press
// strobes while the button is held (first after REPEAT_DELAY cycles, then
// every REPEAT_PERIOD cycles). Without it, REPEAT_* are unused.
//
// state           | meaning
// RELEASED        | stable not-pressed
// CONFIRM_PRESS   | input went pressed, counting stable cycles
// PRESSED         | stable pressed
// CONFIRM_RELEASE | input went released, counting stable cycles
// -----------------------------------------------------------------------------
module button_sync_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
    parameter bit          ACTIVE_HIGH     = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 62_500_000,
    parameter int unsigned REPEAT_PERIOD   = 12_500_000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_button_raw,
    button_sync_debounce_if.master        btn
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic             sync;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             req_q;
    logic             overrun_q;
    logic             repeat_fire;

    // Flops reset to the idle pin level so that sync reads "not pressed"
    // out of reset regardless of ACTIVE_HIGH.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_ff <= {SYNC_STAGES{~ACTIVE_HIGH}};
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_button_raw};
        end
    end

    assign sync = ACTIVE_HIGH ? sync_ff[SYNC_STAGES-1] : ~sync_ff[SYNC_STAGES-1];

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_limit;

    assign rpt_limit   = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
    assign repeat_fire = (state == PRESSED) && sync && ((rpt_cnt + RPT_W'(1)) == rpt_limit);

    // Runs only while stably pressed; holds through CONFIRM_RELEASE so a
    // bounce back to PRESSED resumes, and clears once the release is accepted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == RELEASED || state == CONFIRM_PRESS) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state == PRESSED && sync) begin
            if (repeat_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= RELEASED;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;

            case (state)
                RELEASED: begin
                    if (sync) begin
                        state <= CONFIRM_PRESS;
                        cnt   <= CNT_W'(1);
                    end
                end
                CONFIRM_PRESS: begin
                    if (!sync) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_DONE) begin
                        state   <= PRESSED;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state <= CONFIRM_RELEASE;
                        cnt   <= CNT_W'(1);
                    end else if (repeat_fire) begin
                        press_q <= 1'b1;
                    end
                end
                CONFIRM_RELEASE: begin
                    if (sync) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_DONE) begin
                        state     <= RELEASED;
                        cnt       <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase

            // A new press wins over a simultaneous ack: the request stays up
            // for the newer press and that case is not an overrun.
            if (press_q) begin
                if (req_q && !btn.i_press_ack) begin
                    overrun_q <= 1'b1;
                end
                req_q <= 1'b1;
            end else if (req_q && btn.i_press_ack) begin
                req_q <= 1'b0;
            end
        end
    end

    assign btn.o_button_level  = level_q;
    assign btn.o_press_pulse   = press_q;
    assign btn.o_release_pulse = release_q;
    assign btn.o_press_req     = req_q;
    assign btn.o_overrun       = overrun_q;

endmodule
